uart_tx_arbiter: RTL

Packet-atomic round-robin arbiter that shares the single UART transmitter between several host-bound byte sources, such as command responses, trace streamers and status reporters. It sits between the requesters and the UART TX core. It grants one requester at a time and holds that grant until the requester's packet-terminating byte has been fully shifted out. It sequences each byte into the transmitter with a `tx_start`/`tx_busy` handshake.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The arbiter takes the slave side; requesters plus the UART TX core form the master side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_byte;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 abort;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_byte, tx_start, abort
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_byte, tx_start, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_TX_ARB_WATCHDOG_EN to add the mid-packet stall watchdog (abort pulse).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input logic              clock,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("uart_tx_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {IDLE, HOLD, LAUNCH, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         ptr_q, ptr_d;
    logic               last_q, last_d;
    logic [7:0]         tx_byte_q, tx_byte_d;

    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic [1:0]         owner_idx;
    logic [1:0]         ptr_next;
    logic [NUM_REQ-1:0] pick;
    logic               xfer;
    logic               wd_fire;

    // Owner view of the request bus, selected by the one-hot grant.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        owner_idx   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) begin
                owner_valid = bus.req_valid[j];
                owner_last  = bus.req_last[j];
                owner_data  = bus.req_data[8*j +: 8];
                owner_idx   = 2'(j);
            end
        end
        ptr_next = (32'(owner_idx) + 32'd1 >= NUM_REQ) ? '0 : owner_idx + 2'd1;
    end

    // First valid requester scanning upward from ptr_q with wrap-around.
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned cand;
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && j == cand && bus.req_valid[j]) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    assign xfer = (state_q == HOLD) && owner_valid && !bus.tx_busy;

`ifdef UART_TX_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        abort_q;

    // IDLE clears the count so every fresh grant starts from zero.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_fire  = 1'b0;
        if (xfer || state_q == IDLE) begin
            wd_cnt_d = '0;
        end else if (state_q == HOLD && !owner_valid) begin
            if (wd_cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
                wd_fire  = 1'b1;
                wd_cnt_d = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            abort_q  <= wd_fire;
        end
    end

    assign bus.abort = abort_q;
`else
    assign wd_fire   = 1'b0;
    assign bus.abort = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            last_q    <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            IDLE: begin
                if (|pick) begin
                    grant_d = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    tx_byte_d = owner_data;
                    last_d    = owner_last;
                    state_d   = LAUNCH;
                end else if (wd_fire) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            LAUNCH: state_d = DRAIN;
            DRAIN: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.tx_start  = 1'b0;
        if (state_q == HOLD && !bus.tx_busy) bus.req_ready = grant_q;
        if (state_q == LAUNCH) bus.tx_start = 1'b1;
    end

    assign bus.grant   = grant_q;
    assign bus.tx_byte = tx_byte_q;

endmodule
